// File: rtl/wisc_pkg.sv
// Shared WISC encodings: opcodes, branch condition codes and the flag-stage FSM states.
package wisc_pkg;

    localparam logic [3:0] OpAdd = 4'b0000;
    localparam logic [3:0] OpSub = 4'b0001;
    localparam logic [3:0] OpXor = 4'b0010;
    localparam logic [3:0] OpSll = 4'b0100;
    localparam logic [3:0] OpSra = 4'b0101;
    localparam logic [3:0] OpRor = 4'b0110;
    localparam logic [3:0] OpB   = 4'b1100;
    localparam logic [3:0] OpBr  = 4'b1101;
    localparam logic [3:0] OpHlt = 4'b1111;

    localparam logic [2:0] CondNe = 3'b000;
    localparam logic [2:0] CondEq = 3'b001;
    localparam logic [2:0] CondGt = 3'b010;
    localparam logic [2:0] CondLt = 3'b011;
    localparam logic [2:0] CondGe = 3'b100;
    localparam logic [2:0] CondLe = 3'b101;
    localparam logic [2:0] CondOv = 3'b110;
    localparam logic [2:0] CondUn = 3'b111;

    typedef enum logic [0:0] {StRun, StHalt} state_e;

endpackage

// File: rtl/flag_unit.sv
// Architectural Z/V/N flag register, per-opcode write mask and branch condition evaluation.
// With FLAG_BYPASS_EN defined, conditions see flags being written in the same cycle.
module flag_unit
    import wisc_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        upd,
    input  logic [3:0]  opcode,
    input  logic [15:0] alu_result,
    input  logic        alu_ovfl,
    input  logic        br_en,
    input  logic [2:0]  cond,
    output logic        flag_z,
    output logic        flag_v,
    output logic        flag_n,
    output logic        branch_taken
);

    logic z_q, v_q, n_q;
    logic z_d, v_d, n_d;
    logic wr_nzv, wr_z;
    logic ez, ev, en;
    logic cond_ok;

    always_comb begin
        wr_nzv = 1'b0;
        wr_z   = 1'b0;
        if (upd) begin
            case (opcode)
                OpAdd, OpSub:                 wr_nzv = 1'b1;
                OpXor, OpSll, OpSra, OpRor:   wr_z   = 1'b1;
                default: ;
            endcase
        end
        z_d = (wr_nzv || wr_z) ? (alu_result == 16'h0000) : z_q;
        n_d = wr_nzv ? alu_result[15] : n_q;
        v_d = wr_nzv ? alu_ovfl : v_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            z_q <= 1'b0;
            v_q <= 1'b0;
            n_q <= 1'b0;
        end else begin
            z_q <= z_d;
            v_q <= v_d;
            n_q <= n_d;
        end
    end

`ifdef FLAG_BYPASS_EN
    assign ez = z_d;
    assign ev = v_d;
    assign en = n_d;
`else
    assign ez = z_q;
    assign ev = v_q;
    assign en = n_q;
`endif

    always_comb begin
        cond_ok = 1'b0;
        case (cond)
            CondNe:  cond_ok = ~ez;
            CondEq:  cond_ok = ez;
            CondGt:  cond_ok = ~ez & ~en;
            CondLt:  cond_ok = en;
            CondGe:  cond_ok = ez | (~ez & ~en);
            CondLe:  cond_ok = en | ez;
            CondOv:  cond_ok = ev;
            CondUn:  cond_ok = 1'b1;
            default: cond_ok = 1'b0;
        endcase
    end

    assign branch_taken = br_en && ((opcode == OpB) || (opcode == OpBr)) && cond_ok;
    assign flag_z = z_q;
    assign flag_v = v_q;
    assign flag_n = n_q;

endmodule

// File: rtl/alu_flag_stage.sv
// EX/MEM pipeline register with RUN/HALT FSM; flags and branch resolution live in flag_unit.
// Optional FLAG_BYPASS_EN (see flag_unit) lets conditions use same-cycle flag writes.
module alu_flag_stage
    import wisc_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    input  logic [3:0]  opcode,
    input  logic [15:0] alu_result,
    input  logic        alu_ovfl,
    input  logic [3:0]  dst_reg,
    input  logic        reg_write,
    input  logic [2:0]  cond,
    input  logic        stall,
    input  logic        flush,
    output logic        ex_valid,
    output logic [15:0] ex_result,
    output logic [3:0]  ex_dst,
    output logic        ex_reg_write,
    output logic        flag_z,
    output logic        flag_v,
    output logic        flag_n,
    output logic        branch_taken,
    output logic        halted
);

    state_e state_q, state_d;
    logic   accept;

    assign accept = in_valid && !stall && !flush && (state_q == StRun);

    always_comb begin
        state_d = state_q;
        case (state_q)
            StRun:   if (accept && (opcode == OpHlt)) state_d = StHalt;
            StHalt:  state_d = StHalt;
            default: state_d = StRun;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StRun;
        end else begin
            state_q <= state_d;
        end
    end

    // flush beats stall; a plain bubble also drops the write enable
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid     <= 1'b0;
            ex_result    <= 16'h0000;
            ex_dst       <= 4'h0;
            ex_reg_write <= 1'b0;
        end else if (flush) begin
            ex_valid     <= 1'b0;
            ex_reg_write <= 1'b0;
        end else if (!stall) begin
            ex_valid     <= accept;
            ex_reg_write <= accept && reg_write;
            if (accept) begin
                ex_result <= alu_result;
                ex_dst    <= dst_reg;
            end
        end
    end

    flag_unit u_flag_unit (
        .clk          (clk),
        .rst_n        (rst_n),
        .upd          (accept),
        .opcode       (opcode),
        .alu_result   (alu_result),
        .alu_ovfl     (alu_ovfl),
        .br_en        (in_valid && (state_q == StRun)),
        .cond         (cond),
        .flag_z       (flag_z),
        .flag_v       (flag_v),
        .flag_n       (flag_n),
        .branch_taken (branch_taken)
    );

    assign halted = (state_q == StHalt);

endmodule
